// File: rtl/player_tracker_pkg.sv
// Shared types and constants for the player tracker: FSM state encoding,
// score width/limit and the saturating score increment.
package player_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GROUNDED,
    ST_FLIGHT,
    ST_DEAD
  } state_t;

  localparam int SCORE_W = 10;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 10'd999;

  // Score sticks at SCORE_MAX instead of wrapping.
  function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] value);
    return (value >= SCORE_MAX) ? value : value + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/player_tracker_if.sv
// Game-side bundle for the player tracker: surface/button inputs and
// player status outputs. The master drives inputs; the tracker is the slave.
interface player_tracker_if;
  import player_tracker_pkg::*;

  logic               MoveTick;
  logic [5:0]         Floor;
  logic [5:0]         Ceiling;
  logic               FlipBtn;
  logic               Start;
  logic               PlayerPos;
  logic               InFlight;
  logic               Alive;
  logic               GameOver;
  logic [SCORE_W-1:0] Score;

  modport master (
    output MoveTick, Floor, Ceiling, FlipBtn, Start,
    input  PlayerPos, InFlight, Alive, GameOver, Score
  );

  modport slave (
    input  MoveTick, Floor, Ceiling, FlipBtn, Start,
    output PlayerPos, InFlight, Alive, GameOver, Score
  );

endinterface

// File: rtl/player_tracker_rise_detect.sv
// 1-bit rising-edge detector: pulses for the cycle in which the input is
// first seen high. Synchronous active-low reset.
module rise_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge Clk) begin
    if (!Rst) r_prev <= 1'b0;
    else      r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/player_tracker.sv
// Gravity-flip runner player tracker: grounded/flight/dead FSM with score.
// Optional PLAYER_TRACKER_GRACE_EN tolerates one unsupported grounded tick.
module player_tracker
  import player_tracker_pkg::*;
#(
  parameter int PLAYER_COL = 1,
  parameter int FLIP_TICKS = 2
) (
  input logic            Clk,
  input logic            Rst,
  player_tracker_if.slave bus
);

  localparam logic [2:0] FLIP_TICKS_L = 3'(FLIP_TICKS);

  state_t             r_state, w_stateNext;
  logic               r_tickD;
  logic               r_pos, w_posNext;
  logic [SCORE_W-1:0] r_score, w_scoreNext;
  logic [2:0]         r_flightCnt, w_flightCntNext;
  logic               r_gameOver, w_gameOverNext;
`ifdef PLAYER_TRACKER_GRACE_EN
  logic               r_grace, w_graceNext;
`endif

  logic               w_flipRise;
  logic               w_eval;
  logic               w_support;
  logic               w_landSupport;
  logic [2:0]         w_flightCntInc;

  rise_detect u_flipRise (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_d    (bus.FlipBtn),
    .o_rise (w_flipRise)
  );

  // Evaluation runs one cycle after MoveTick so it sees the shifted surfaces.
  assign w_eval         = r_tickD;
  assign w_support      = r_pos ? bus.Ceiling[PLAYER_COL] : bus.Floor[PLAYER_COL];
  assign w_landSupport  = r_pos ? bus.Floor[PLAYER_COL] : bus.Ceiling[PLAYER_COL];
  assign w_flightCntInc = r_flightCnt + 3'd1;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state     <= ST_IDLE;
      r_tickD     <= 1'b0;
      r_pos       <= 1'b0;
      r_score     <= '0;
      r_flightCnt <= '0;
      r_gameOver  <= 1'b0;
`ifdef PLAYER_TRACKER_GRACE_EN
      r_grace     <= 1'b0;
`endif
    end else begin
      r_state     <= w_stateNext;
      r_tickD     <= bus.MoveTick;
      r_pos       <= w_posNext;
      r_score     <= w_scoreNext;
      r_flightCnt <= w_flightCntNext;
      r_gameOver  <= w_gameOverNext;
`ifdef PLAYER_TRACKER_GRACE_EN
      r_grace     <= w_graceNext;
`endif
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_posNext       = r_pos;
    w_scoreNext     = r_score;
    w_flightCntNext = r_flightCnt;
    w_gameOverNext  = 1'b0;
`ifdef PLAYER_TRACKER_GRACE_EN
    w_graceNext     = r_grace;
`endif

    case (r_state)
      ST_IDLE, ST_DEAD: begin
        if (bus.Start) begin
          w_stateNext     = ST_GROUNDED;
          w_posNext       = 1'b0;
          w_scoreNext     = '0;
          w_flightCntNext = '0;
`ifdef PLAYER_TRACKER_GRACE_EN
          w_graceNext     = 1'b0;
`endif
        end
      end

      ST_GROUNDED: begin
        // An unsupported evaluation wins over a simultaneous flip edge.
        if (w_eval && !w_support) begin
`ifdef PLAYER_TRACKER_GRACE_EN
          if (!r_grace) begin
            w_graceNext = 1'b1;
          end else begin
            w_stateNext    = ST_DEAD;
            w_gameOverNext = 1'b1;
          end
`else
          w_stateNext    = ST_DEAD;
          w_gameOverNext = 1'b1;
`endif
        end else begin
          if (w_eval) begin
            w_scoreNext = satInc(r_score);
`ifdef PLAYER_TRACKER_GRACE_EN
            w_graceNext = 1'b0;
`endif
          end
          if (w_flipRise) begin
            w_stateNext     = ST_FLIGHT;
            w_flightCntNext = '0;
          end
        end
      end

      ST_FLIGHT: begin
        if (w_eval) begin
          w_scoreNext     = satInc(r_score);
          w_flightCntNext = w_flightCntInc;
          if (w_flightCntInc == FLIP_TICKS_L) begin
            w_posNext = ~r_pos;
            if (w_landSupport) begin
              w_stateNext = ST_GROUNDED;
            end else begin
              w_stateNext    = ST_DEAD;
              w_gameOverNext = 1'b1;
            end
          end
        end
      end

      default: w_stateNext = ST_IDLE;
    endcase
  end

  assign bus.PlayerPos = r_pos;
  assign bus.InFlight  = (r_state == ST_FLIGHT);
  assign bus.Alive     = (r_state == ST_GROUNDED) || (r_state == ST_FLIGHT);
  assign bus.GameOver  = r_gameOver;
  assign bus.Score     = r_score;

endmodule

// File: tb/tb_player_tracker.sv
// Self-checking bench for player_tracker: fixed vector table, hand-written
// corner sequences and randomized play against a game-rule model.
module tb_player_tracker;
  import player_tracker_pkg::*;

  localparam int COL   = 1;
  localparam int FLIPS = 2;
`ifdef PLAYER_TRACKER_GRACE_EN
  localparam bit GRACE = 1'b1;
`else
  localparam bit GRACE = 1'b0;
`endif

  localparam int M_IDLE = 0, M_GROUND = 1, M_FLIGHT = 2, M_DEAD = 3;
  localparam logic [5:0] SOLID = 6'b111111;
  localparam logic [5:0] GAP   = 6'b111101;

  logic Clk;
  logic Rst;
  int   total = 0;
  int   bad   = 0;

  player_tracker_if pif ();

  player_tracker #(.PLAYER_COL(COL), .FLIP_TICKS(FLIPS)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (pif)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int mMode, mScore, mFlightLeft;
  bit mPos, mGo, mGrace, mTickPending, mBtnPrev;

  // Game-rule model: one call per clock with the inputs present at that edge.
  task automatic modelStep(input logic rst, mt, fb, st, input logic [5:0] fl, ce);
    bit evalNow, flipEdge, sup;
    if (!rst) begin
      mMode = M_IDLE; mScore = 0; mFlightLeft = 0;
      mPos = 0; mGo = 0; mGrace = 0; mTickPending = 0; mBtnPrev = 0;
    end else begin
      evalNow      = mTickPending;
      mTickPending = mt;
      flipEdge     = fb && !mBtnPrev;
      mBtnPrev     = fb;
      mGo          = 0;
      if (mMode == M_IDLE || mMode == M_DEAD) begin
        if (st) begin
          mMode = M_GROUND; mPos = 0; mScore = 0; mFlightLeft = 0; mGrace = 0;
        end
      end else if (mMode == M_GROUND) begin
        sup = mPos ? ce[COL] : fl[COL];
        if (evalNow && !sup) begin
          if (GRACE && !mGrace) mGrace = 1;
          else begin mMode = M_DEAD; mGo = 1; end
        end else begin
          if (evalNow) begin
            mScore = (mScore < 999) ? mScore + 1 : 999;
            mGrace = 0;
          end
          if (flipEdge) begin mMode = M_FLIGHT; mFlightLeft = FLIPS; end
        end
      end else begin
        if (evalNow) begin
          mScore = (mScore < 999) ? mScore + 1 : 999;
          mFlightLeft--;
          if (mFlightLeft == 0) begin
            mPos = !mPos;
            sup  = mPos ? ce[COL] : fl[COL];
            if (sup) mMode = M_GROUND;
            else begin mMode = M_DEAD; mGo = 1; end
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, mt, fb, st, input logic [5:0] fl, ce);
    @(negedge Clk);
    Rst          = rst;
    pif.MoveTick = mt;
    pif.FlipBtn  = fb;
    pif.Start    = st;
    pif.Floor    = fl;
    pif.Ceiling  = ce;
    modelStep(rst, mt, fb, st, fl, ce);
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic pos, inF, alive, go, input int score);
    total++;
    if (pif.PlayerPos !== pos || pif.InFlight !== inF || pif.Alive !== alive ||
        pif.GameOver !== go || int'(pif.Score) != score) begin
      bad++;
      $display("[TB] FAIL %s: got pos=%0b inFlight=%0b alive=%0b gameOver=%0b score=%0d, want pos=%0b inFlight=%0b alive=%0b gameOver=%0b score=%0d",
               name, pif.PlayerPos, pif.InFlight, pif.Alive, pif.GameOver, pif.Score,
               pos, inF, alive, go, score);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mPos, mMode == M_FLIGHT, mMode == M_GROUND || mMode == M_FLIGHT,
                mGo, mScore);
  endtask

  task automatic tick(input logic [5:0] fl, ce);
    applyStimulus(1, 1, 0, 0, fl, ce);
    applyStimulus(1, 0, 0, 0, fl, ce);
  endtask

  task automatic restart(input logic [5:0] fl, ce);
    applyStimulus(0, 0, 0, 0, fl, ce);
    applyStimulus(1, 0, 0, 1, fl, ce);
  endtask

  typedef struct {
    logic       rst, mt, fb, st;
    logic [5:0] fl, ce;
    logic       ePos, eInF, eAlive, eGo;
    int         eScore;
  } vec_t;

  function automatic vec_t mk(input logic rst, mt, fb, st, input logic [5:0] fl, ce,
                              input logic ePos, eInF, eAlive, eGo, input int eScore);
    vec_t v;
    v.rst = rst; v.mt = mt; v.fb = fb; v.st = st; v.fl = fl; v.ce = ce;
    v.ePos = ePos; v.eInF = eInF; v.eAlive = eAlive; v.eGo = eGo; v.eScore = eScore;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    logic       fbLevel;
    logic [5:0] rf, rc;

    Rst = 1'b0;
    pif.MoveTick = 0; pif.FlipBtn = 0; pif.Start = 0; pif.Floor = '0; pif.Ceiling = '0;

    vecs[0]  = mk(0, 0, 0, 0, SOLID, 0,     0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, SOLID, 0,     0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 1, SOLID, 0,     0, 0, 1, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, SOLID, 0,     0, 0, 1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, SOLID, 0,     0, 0, 1, 0, 1);
    vecs[5]  = mk(1, 1, 0, 0, SOLID, 0,     0, 0, 1, 0, 1);
    vecs[6]  = mk(1, 0, 1, 0, SOLID, SOLID, 0, 1, 1, 0, 2);
    vecs[7]  = mk(1, 1, 1, 0, SOLID, SOLID, 0, 1, 1, 0, 2);
    vecs[8]  = mk(1, 0, 0, 0, SOLID, SOLID, 0, 1, 1, 0, 3);
    vecs[9]  = mk(1, 1, 0, 0, SOLID, SOLID, 0, 1, 1, 0, 3);
    vecs[10] = mk(1, 0, 0, 0, SOLID, SOLID, 1, 0, 1, 0, 4);
    vecs[11] = mk(1, 1, 0, 0, SOLID, GAP,   1, 0, 1, 0, 4);
`ifdef PLAYER_TRACKER_GRACE_EN
    vecs[12] = mk(1, 0, 0, 0, SOLID, GAP,   1, 0, 1, 0, 4);
    vecs[13] = mk(1, 1, 0, 0, SOLID, GAP,   1, 0, 1, 0, 4);
    vecs[14] = mk(1, 0, 0, 0, SOLID, GAP,   1, 0, 0, 1, 4);
`else
    vecs[12] = mk(1, 0, 0, 0, SOLID, GAP,   1, 0, 0, 1, 4);
    vecs[13] = mk(1, 1, 0, 0, SOLID, GAP,   1, 0, 0, 0, 4);
    vecs[14] = mk(1, 0, 0, 0, SOLID, GAP,   1, 0, 0, 0, 4);
`endif
    vecs[15] = mk(1, 0, 0, 1, SOLID, SOLID, 0, 0, 1, 0, 0);
    vecs[16] = mk(1, 0, 1, 0, SOLID, SOLID, 0, 1, 1, 0, 0);
    vecs[17] = mk(0, 1, 1, 0, SOLID, SOLID, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 0, 0, 0, SOLID, SOLID, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 1, 0, 0, SOLID, SOLID, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 0, 0, 0, SOLID, SOLID, 0, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].mt, vecs[i].fb, vecs[i].st, vecs[i].fl, vecs[i].ce);
      checkOutput($sformatf("vec%0d", i), vecs[i].ePos, vecs[i].eInF, vecs[i].eAlive,
                  vecs[i].eGo, vecs[i].eScore);
    end

    // Ten solid ticks from a fresh start.
    restart(SOLID, 0);
    checkOutput("startGrounded", 0, 0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick(SOLID, 0);
      checkOutput($sformatf("survive%0d", i), 0, 0, 1, 0, i);
    end

`ifdef PLAYER_TRACKER_GRACE_EN
    tick(GAP, 0);
    checkOutput("graceFirstGap", 0, 0, 1, 0, 10);
    tick(SOLID, 0);
    checkOutput("graceCleared", 0, 0, 1, 0, 11);
    tick(GAP, 0);
    checkOutput("graceGapAgain", 0, 0, 1, 0, 11);
    tick(GAP, 0);
    checkOutput("graceSecondGap", 0, 0, 0, 1, 11);
`else
    applyStimulus(1, 1, 0, 0, GAP, 0);
    checkOutput("gapTickSeen", 0, 0, 1, 0, 10);
    applyStimulus(1, 0, 0, 0, GAP, 0);
    checkOutput("gapDeath", 0, 0, 0, 1, 10);
    applyStimulus(1, 0, 0, 0, GAP, 0);
    checkOutput("deadFrozen", 0, 0, 0, 0, 10);
    applyStimulus(1, 0, 1, 0, SOLID, SOLID);
    checkOutput("deadIgnoresFlip", 0, 0, 0, 0, 10);
`endif

    // Flip edge coinciding with an unsupported evaluation.
    restart(SOLID, SOLID);
    applyStimulus(1, 1, 0, 0, SOLID, SOLID);
    applyStimulus(1, 0, 1, 0, GAP, SOLID);
`ifdef PLAYER_TRACKER_GRACE_EN
    checkOutput("flipVsGap", 0, 0, 1, 0, 0);
`else
    checkOutput("flipVsGap", 0, 0, 0, 1, 0);
`endif

    // Score saturation.
    restart(SOLID, 0);
    for (int i = 0; i < 998; i++) tick(SOLID, 0);
    checkOutput("score998", 0, 0, 1, 0, 998);
    for (int i = 1; i <= 3; i++) begin
      tick(SOLID, 0);
      checkOutput($sformatf("scoreSat%0d", i), 0, 0, 1, 0, 999);
    end

    // Randomized play against the model.
    restart(SOLID, SOLID);
    fbLevel = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 4) == 0) fbLevel = ~fbLevel;
      for (int b = 0; b < 6; b++) begin
        rf[b] = ($urandom_range(0, 5) != 0);
        rc[b] = ($urandom_range(0, 5) != 0);
      end
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0, fbLevel,
                    $urandom_range(0, 29) == 0, rf, rc);
      checkModel($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_tracker.md
PLAYER_TRACKER -- requirements
Module: player_tracker

Interface
REQ-001 SHALL have parameter PLAYER_COL, default 1: index of the Floor/Ceiling bit under the player (0..5).
REQ-002 SHALL have parameter FLIP_TICKS, default 2: evaluated ticks spent in flight per flip (1..7).
REQ-003 SHALL have port Clk  input  1  system clock; all logic is on posedge.
REQ-004 SHALL have port Rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port MoveTick  input  1  one-cycle pulse; the same tick that shifts the surface registers.
REQ-006 SHALL have port Floor  input  6  floor column pattern; 1 = solid.
REQ-007 SHALL have port Ceiling  input  6  ceiling column pattern; 1 = solid.
REQ-008 SHALL have port FlipBtn  input  1  debounced flip button, level.
REQ-009 SHALL have port Start  input  1  one-cycle start/restart pulse.
REQ-010 SHALL have port PlayerPos  output  1  0 = on floor, 1 = on ceiling.
REQ-011 SHALL have port InFlight  output  1  high while in the FLIGHT state.
REQ-012 SHALL have port Alive  output  1  high in the GROUNDED and FLIGHT states.
REQ-013 SHALL have port GameOver  output  1  one-cycle pulse on entry to DEAD.
REQ-014 SHALL have port Score  output  10  binary count of survived ticks, saturating at 999.

Function
REQ-015 SHALL implement the FSM states IDLE, GROUNDED, FLIGHT, DEAD.
REQ-016 SHALL delay MoveTick by one register stage; the delayed pulse is the "evaluation" cycle, so evaluation sees the post-shift Floor/Ceiling.
REQ-017 SHALL define support as Floor[PLAYER_COL] when PlayerPos=0 and Ceiling[PLAYER_COL] when PlayerPos=1.
REQ-018 SHALL, in IDLE or DEAD on Start: go to GROUNDED, set PlayerPos=0, clear Score, clear the flight counter, clear the grace flag.
REQ-019 SHALL, in GROUNDED at evaluation: if unsupported, go to DEAD (subject to REQ-028); otherwise increment Score.
REQ-020 SHALL detect a rising edge of FlipBtn (registered previous level) and act on it only in GROUNDED: go to FLIGHT and set the flight counter to 0.
REQ-021 SHALL give the support check priority over a flip when a flip edge and an evaluation coincide in GROUNDED: if unsupported, go to DEAD and ignore the flip; if supported, increment Score and go to FLIGHT.
REQ-022 SHALL, in FLIGHT at each evaluation: skip the support check, increment Score, and increment the flight counter.
REQ-023 SHALL, in FLIGHT when the counter reaches FLIP_TICKS: toggle PlayerPos, check support at the new position in that same cycle, and go to GROUNDED or DEAD accordingly.
REQ-024 SHALL ignore flip edges in IDLE, FLIGHT and DEAD, and ignore Start in GROUNDED and FLIGHT.
REQ-025 SHALL hold Score at 999 once reached; Score SHALL NOT wrap.
REQ-026 SHALL, in DEAD, hold PlayerPos and Score frozen for display.

Reset
REQ-027 SHALL, while Rst=0, force on the next edge: state IDLE, PlayerPos=0, InFlight=0, Alive=0, GameOver=0, Score=0, counters/flags/edge and tick registers=0; mid-game reset SHALL abort to IDLE with no GameOver pulse.

Configuration
REQ-028 SHALL, with PLAYER_TRACKER_GRACE_EN defined, tolerate one unsupported evaluation in GROUNDED by setting a grace flag; a second consecutive unsupported evaluation goes to DEAD, and a supported evaluation clears the flag. Without the macro, the first unsupported evaluation goes to DEAD and no grace flag exists.

Structure
REQ-029 SHALL take from shared package player_tracker_pkg the state typedef, SCORE_W=10 and SCORE_MAX=999.
REQ-030 SHALL instantiate sub-module rise_detect (1-bit rising-edge detector with sync active-low reset) for FlipBtn.

Verification
REQ-031 SHALL cover: Start, Floor=6'b111111, 10 MoveTicks -> Alive=1, Score=10, PlayerPos=0, no GameOver.
REQ-032 SHALL cover: grounded, Floor[1] cleared before a tick (macro off) -> GameOver pulse 2 cycles after MoveTick, Alive=0, Score frozen.
REQ-033 SHALL cover: FlipBtn rise, FLIP_TICKS=2, Ceiling=6'b111111 -> InFlight for 2 evaluations, then PlayerPos=1, GROUNDED, Score +2.
REQ-034 SHALL cover: flip edge on the same cycle as an unsupported evaluation -> DEAD, PlayerPos unchanged.
REQ-035 SHALL cover: Score preloaded to 998 via ticks, 3 more ticks -> Score=999.
REQ-036 SHALL cover: Rst=0 during FLIGHT -> IDLE next edge, all outputs 0, no GameOver; with PLAYER_TRACKER_GRACE_EN, one gap tick survived and two consecutive gap ticks -> DEAD.
